// File: rtl/decode_pkg.sv
// decode_pkg: shared constants and types for the RV32I decode stage.
//   - ALU operation codes driven on out_alu_ctrl
//   - base opcode and funct7 encodings
//   - control-bundle field widths, the control-bundle struct and the
//     immediate-format enum used by the immediate generator
//   - state type for the output/skid buffer FSM
package decode_pkg;

    // ALU operation codes
    localparam logic [3:0] ALU_AND   = 4'b0000;
    localparam logic [3:0] ALU_OR    = 4'b0001;
    localparam logic [3:0] ALU_ADD   = 4'b0010;
    localparam logic [3:0] ALU_XOR   = 4'b0011;
    localparam logic [3:0] ALU_SLL   = 4'b0100;
    localparam logic [3:0] ALU_SRL   = 4'b0101;
    localparam logic [3:0] ALU_SUB   = 4'b0110;
    localparam logic [3:0] ALU_SLT   = 4'b0111;
    localparam logic [3:0] ALU_SLTU  = 4'b1000;
    localparam logic [3:0] ALU_SRA   = 4'b1001;
    localparam logic [3:0] ALU_PASSB = 4'b1010;

    // RV32I base opcodes (instr[6:0])
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_FENCE  = 7'b0001111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    // funct7 encodings for R-type and immediate shifts
    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    // Control-bundle field widths
    localparam int unsigned REG_W = 5;
    localparam int unsigned F3_W  = 3;
    localparam int unsigned ALU_W = 4;

    typedef enum logic [2:0] {
        FMT_NONE,
        FMT_R,
        FMT_I,
        FMT_S,
        FMT_B,
        FMT_U,
        FMT_J
    } fmt_e;

    typedef enum logic [1:0] {
        ST_EMPTY,
        ST_ONE,
        ST_TWO
    } skid_state_e;

    typedef struct packed {
        logic [REG_W-1:0] rs1;
        logic [REG_W-1:0] rs2;
        logic [REG_W-1:0] rd;
        logic [F3_W-1:0]  func3;
        logic [ALU_W-1:0] alu_ctrl;
        logic             alu_src;
        logic             pc_src;
        logic             mem_read;
        logic             mem_write;
        logic             reg_write;
        logic             mem_to_reg;
        logic             branch;
        logic             jump;
        logic             illegal;
    } ctrl_t;

    // 32-bit immediate for the given format, sign-extended from instr[31].
    function automatic logic [31:0] imm_gen(input logic [31:0] i, input fmt_e fmt);
        case (fmt)
            FMT_I:   imm_gen = {{20{i[31]}}, i[31:20]};
            FMT_S:   imm_gen = {{20{i[31]}}, i[31:25], i[11:7]};
            FMT_B:   imm_gen = {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
            FMT_U:   imm_gen = {i[31:12], 12'b0};
            FMT_J:   imm_gen = {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
            default: imm_gen = '0;
        endcase
    endfunction

endpackage

// File: rtl/decode_if.sv
// decode_if: fetch-side and execute-side handshake bundle of the decode stage.
//   fetch side : in_valid, in_ready, in_instr, in_pc, flush
//   execute side: out_valid, out_ready and the decoded out_* fields
// modport slave is the decode stage; modport master is its environment.
interface decode_if
    import decode_pkg::*;
#(
    parameter int unsigned XLEN = 32,
    parameter int unsigned PC_W = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      in_instr;
    logic [PC_W-1:0]  in_pc;
    logic             flush;

    logic             out_valid;
    logic             out_ready;
    logic [PC_W-1:0]  out_pc;
    logic [XLEN-1:0]  out_imm;
    logic [REG_W-1:0] out_rs1;
    logic [REG_W-1:0] out_rs2;
    logic [REG_W-1:0] out_rd;
    logic [F3_W-1:0]  out_func3;
    logic [ALU_W-1:0] out_alu_ctrl;
    logic             out_alu_src;
    logic             out_pc_src;
    logic             out_mem_read;
    logic             out_mem_write;
    logic             out_reg_write;
    logic             out_mem_to_reg;
    logic             out_branch;
    logic             out_jump;
    logic             out_illegal;

    modport slave (
        input  in_valid, in_instr, in_pc, flush, out_ready,
        output in_ready, out_valid, out_pc, out_imm, out_rs1, out_rs2, out_rd,
               out_func3, out_alu_ctrl, out_alu_src, out_pc_src, out_mem_read,
               out_mem_write, out_reg_write, out_mem_to_reg, out_branch,
               out_jump, out_illegal
    );

    modport master (
        output in_valid, in_instr, in_pc, flush, out_ready,
        input  in_ready, out_valid, out_pc, out_imm, out_rs1, out_rs2, out_rd,
               out_func3, out_alu_ctrl, out_alu_src, out_pc_src, out_mem_read,
               out_mem_write, out_reg_write, out_mem_to_reg, out_branch,
               out_jump, out_illegal
    );

endinterface

// File: rtl/decode_comb.sv
// decode_comb: purely combinational RV32I instruction cracker.
//   instr : raw 32-bit instruction
//   imm   : format immediate, sign-extended to XLEN (0 for R-type / NOP)
//   ctrl  : control bundle; register fields are zero where the format has
//           none, and an illegal encoding yields an all-zero bundle with
//           only the illegal flag set.
module decode_comb
    import decode_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic [31:0]     instr,
    output logic [XLEN-1:0] imm,
    output ctrl_t           ctrl
);

    logic [6:0] opcode;
    logic [2:0] f3;
    logic [6:0] f7;
    ctrl_t      c;
    fmt_e       fmt;
    logic       legal;

    assign opcode = instr[6:0];
    assign f3     = instr[14:12];
    assign f7     = instr[31:25];

    always_comb begin
        c     = '0;
        fmt   = FMT_NONE;
        legal = 1'b1;

        case (opcode)
            OP_LUI: begin
                fmt         = FMT_U;
                c.alu_ctrl  = ALU_PASSB;
                c.alu_src   = 1'b1;
                c.reg_write = 1'b1;
            end
            OP_AUIPC: begin
                fmt         = FMT_U;
                c.alu_ctrl  = ALU_ADD;
                c.alu_src   = 1'b1;
                c.pc_src    = 1'b1;
                c.reg_write = 1'b1;
            end
            OP_JAL: begin
                fmt         = FMT_J;
                c.alu_ctrl  = ALU_ADD;
                c.alu_src   = 1'b1;
                c.pc_src    = 1'b1;
                c.reg_write = 1'b1;
                c.jump      = 1'b1;
            end
            OP_JALR: begin
                fmt         = FMT_I;
                legal       = (f3 == 3'b000);
                c.alu_ctrl  = ALU_ADD;
                c.alu_src   = 1'b1;
                c.pc_src    = 1'b1;
                c.reg_write = 1'b1;
                c.jump      = 1'b1;
            end
            OP_BRANCH: begin
                fmt      = FMT_B;
                legal    = (f3[2:1] != 2'b01);
                c.branch = 1'b1;
                case (f3[2:1])
                    2'b00:   c.alu_ctrl = ALU_SUB;
                    2'b10:   c.alu_ctrl = ALU_SLT;
                    default: c.alu_ctrl = ALU_SLTU;
                endcase
            end
            OP_LOAD: begin
                // legal widths: LB LH LW LBU LHU
                fmt          = FMT_I;
                legal        = (f3 != 3'b011) && (f3[2:1] != 2'b11);
                c.alu_ctrl   = ALU_ADD;
                c.alu_src    = 1'b1;
                c.mem_read   = 1'b1;
                c.mem_to_reg = 1'b1;
                c.reg_write  = 1'b1;
            end
            OP_STORE: begin
                // legal widths: SB SH SW
                fmt         = FMT_S;
                legal       = !f3[2] && (f3[1:0] != 2'b11);
                c.alu_ctrl  = ALU_ADD;
                c.alu_src   = 1'b1;
                c.mem_write = 1'b1;
            end
            OP_IMM: begin
                fmt         = FMT_I;
                c.alu_src   = 1'b1;
                c.reg_write = 1'b1;
                case (f3)
                    3'b000: c.alu_ctrl = ALU_ADD;
                    3'b001: begin
                        c.alu_ctrl = ALU_SLL;
                        legal      = (f7 == F7_BASE);
                    end
                    3'b010: c.alu_ctrl = ALU_SLT;
                    3'b011: c.alu_ctrl = ALU_SLTU;
                    3'b100: c.alu_ctrl = ALU_XOR;
                    3'b101: begin
                        c.alu_ctrl = instr[30] ? ALU_SRA : ALU_SRL;
                        legal      = (f7 == F7_BASE) || (f7 == F7_ALT);
                    end
                    3'b110: c.alu_ctrl = ALU_OR;
                    3'b111: c.alu_ctrl = ALU_AND;
                endcase
            end
            OP_REG: begin
                fmt         = FMT_R;
                c.reg_write = 1'b1;
                if (f7 == F7_BASE) begin
                    case (f3)
                        3'b000: c.alu_ctrl = ALU_ADD;
                        3'b001: c.alu_ctrl = ALU_SLL;
                        3'b010: c.alu_ctrl = ALU_SLT;
                        3'b011: c.alu_ctrl = ALU_SLTU;
                        3'b100: c.alu_ctrl = ALU_XOR;
                        3'b101: c.alu_ctrl = ALU_SRL;
                        3'b110: c.alu_ctrl = ALU_OR;
                        3'b111: c.alu_ctrl = ALU_AND;
                    endcase
                end else if (f7 == F7_ALT && f3 == 3'b000) begin
                    c.alu_ctrl = ALU_SUB;
                end else if (f7 == F7_ALT && f3 == 3'b101) begin
                    c.alu_ctrl = ALU_SRA;
                end else begin
                    legal = 1'b0;
                end
            end
            OP_FENCE, OP_SYSTEM: begin
                // FENCE / ECALL / EBREAK: architectural NOP at this stage
            end
            default: legal = 1'b0;
        endcase

        if (fmt inside {FMT_R, FMT_I, FMT_S, FMT_B}) begin
            c.rs1   = instr[19:15];
            c.func3 = f3;
        end
        if (fmt inside {FMT_R, FMT_S, FMT_B}) begin
            c.rs2 = instr[24:20];
        end
        if (fmt inside {FMT_R, FMT_I, FMT_U, FMT_J}) begin
            c.rd = instr[11:7];
        end
        if (c.rd == '0) begin
            c.reg_write = 1'b0;
        end

        // Illegal encodings still flow down the pipe as a flagged NOP.
        if (!legal) begin
            c         = '0;
            c.illegal = 1'b1;
            fmt       = FMT_NONE;
        end

        ctrl = c;
        imm  = XLEN'($signed(imm_gen(instr, fmt)));
    end

endmodule

// File: rtl/decode_pipe.sv
// decode_pipe: RV32I decode stage between fetch and execute.
//   clk  : clock, all state on posedge
//   rst  : asynchronous, active-low reset
//   bus  : decode_if.slave -- fetch handshake (in_*, flush) and the
//          registered decoded bundle with execute handshake (out_*)
// An instruction accepted in cycle N is presented on out_* in cycle N+1.
// SKID_EN=1 adds a second (skid) entry so in_ready can be registered;
// SKID_EN=0 uses a single output entry with combinational in_ready.
module decode_pipe
    import decode_pkg::*;
#(
    parameter int unsigned XLEN    = 32,
    parameter int unsigned PC_W    = 32,
    parameter bit          SKID_EN = 1'b1
) (
    input logic   clk,
    input logic   rst,
    decode_if.slave bus
);

    ctrl_t           dec_ctrl;
    logic [XLEN-1:0] dec_imm;

    ctrl_t           out_ctrl;
    logic [XLEN-1:0] out_imm_q;
    logic [PC_W-1:0] out_pc_q;
    logic            out_valid_q;
    logic            in_ready_w;
    logic            accept;

    decode_comb #(
        .XLEN (XLEN)
    ) u_decode_comb (
        .instr (bus.in_instr),
        .imm   (dec_imm),
        .ctrl  (dec_ctrl)
    );

    // Beats offered during a flush are dropped.
    assign accept = bus.in_valid & in_ready_w & ~bus.flush;

    generate
        if (SKID_EN) begin : g_skid
            skid_state_e     state;
            ctrl_t           skid_ctrl;
            logic [XLEN-1:0] skid_imm;
            logic [PC_W-1:0] skid_pc;
            logic            in_ready_q;

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    state       <= ST_EMPTY;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                    out_ctrl    <= '0;
                    out_imm_q   <= '0;
                    out_pc_q    <= '0;
                    skid_ctrl   <= '0;
                    skid_imm    <= '0;
                    skid_pc     <= '0;
                end else if (bus.flush) begin
                    state       <= ST_EMPTY;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                end else begin
                    case (state)
                        ST_EMPTY: begin
                            if (accept) begin
                                out_ctrl    <= dec_ctrl;
                                out_imm_q   <= dec_imm;
                                out_pc_q    <= bus.in_pc;
                                out_valid_q <= 1'b1;
                                state       <= ST_ONE;
                            end
                        end
                        ST_ONE: begin
                            if (accept && bus.out_ready) begin
                                out_ctrl  <= dec_ctrl;
                                out_imm_q <= dec_imm;
                                out_pc_q  <= bus.in_pc;
                            end else if (accept) begin
                                // output stalled: park the new beat behind it
                                skid_ctrl  <= dec_ctrl;
                                skid_imm   <= dec_imm;
                                skid_pc    <= bus.in_pc;
                                state      <= ST_TWO;
                                in_ready_q <= 1'b0;
                            end else if (bus.out_ready) begin
                                out_valid_q <= 1'b0;
                                state       <= ST_EMPTY;
                            end
                        end
                        ST_TWO: begin
                            if (bus.out_ready) begin
                                out_ctrl   <= skid_ctrl;
                                out_imm_q  <= skid_imm;
                                out_pc_q   <= skid_pc;
                                state      <= ST_ONE;
                                in_ready_q <= 1'b1;
                            end
                        end
                        default: begin
                            state       <= ST_EMPTY;
                            in_ready_q  <= 1'b1;
                            out_valid_q <= 1'b0;
                        end
                    endcase
                end
            end

            assign in_ready_w = in_ready_q;
        end else begin : g_single
            assign in_ready_w = ~out_valid_q | bus.out_ready;

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    out_valid_q <= 1'b0;
                    out_ctrl    <= '0;
                    out_imm_q   <= '0;
                    out_pc_q    <= '0;
                end else if (bus.flush) begin
                    out_valid_q <= 1'b0;
                end else if (accept) begin
                    out_ctrl    <= dec_ctrl;
                    out_imm_q   <= dec_imm;
                    out_pc_q    <= bus.in_pc;
                    out_valid_q <= 1'b1;
                end else if (bus.out_ready) begin
                    out_valid_q <= 1'b0;
                end
            end
        end
    endgenerate

    assign bus.in_ready       = in_ready_w;
    assign bus.out_valid      = out_valid_q;
    assign bus.out_pc         = out_pc_q;
    assign bus.out_imm        = out_imm_q;
    assign bus.out_rs1        = out_ctrl.rs1;
    assign bus.out_rs2        = out_ctrl.rs2;
    assign bus.out_rd         = out_ctrl.rd;
    assign bus.out_func3      = out_ctrl.func3;
    assign bus.out_alu_ctrl   = out_ctrl.alu_ctrl;
    assign bus.out_alu_src    = out_ctrl.alu_src;
    assign bus.out_pc_src     = out_ctrl.pc_src;
    assign bus.out_mem_read   = out_ctrl.mem_read;
    assign bus.out_mem_write  = out_ctrl.mem_write;
    assign bus.out_reg_write  = out_ctrl.reg_write;
    assign bus.out_mem_to_reg = out_ctrl.mem_to_reg;
    assign bus.out_branch     = out_ctrl.branch;
    assign bus.out_jump       = out_ctrl.jump;
    assign bus.out_illegal    = out_ctrl.illegal;

endmodule

// File: tb/tb_decode_pipe.sv
module tb_decode_pipe;

    localparam logic [3:0] A_AND = 4'd0, A_OR = 4'd1, A_ADD = 4'd2, A_XOR = 4'd3;
    localparam logic [3:0] A_SLL = 4'd4, A_SRL = 4'd5, A_SUB = 4'd6, A_SLT = 4'd7;
    localparam logic [3:0] A_SLTU = 4'd8, A_SRA = 4'd9, A_PASSB = 4'd10;

    // ALU op for base-funct7 register/immediate ops, indexed by funct3
    localparam logic [3:0] R_ALU [8] = '{A_ADD, A_SLL, A_SLT, A_SLTU, A_XOR, A_SRL, A_OR, A_AND};
    localparam logic [6:0] OPS [11] = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03,
                                        7'h23, 7'h13, 7'h33, 7'h0F, 7'h73};

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] imm;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [2:0]  func3;
        logic [3:0]  alu;
        logic        alu_src;
        logic        pc_src;
        logic        mem_read;
        logic        mem_write;
        logic        reg_write;
        logic        mem_to_reg;
        logic        branch;
        logic        jump;
        logic        illegal;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   errors = 0;
    exp_t q[$];

    always #5 clk = ~clk;

    decode_if #(.XLEN(32), .PC_W(32)) bus ();

    decode_pipe #(.XLEN(32), .PC_W(32), .SKID_EN(1'b1)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // ---------------- reference model ----------------
    function automatic logic [31:0] sx(input logic [31:0] mag, input logic neg, input int unsigned span);
        sx = neg ? mag - (32'd1 << span) : mag;
    endfunction

    function automatic exp_t ref_decode(input logic [31:0] ins, input logic [31:0] pc);
        exp_t e;
        logic [6:0] op;
        logic [2:0] f3;
        logic [6:0] f7;
        logic has_rs1, has_rs2, has_rd, bad;
        e = '0;
        e.pc = pc;
        op = ins[6:0];
        f3 = ins[14:12];
        f7 = ins[31:25];
        has_rs1 = 0; has_rs2 = 0; has_rd = 0; bad = 0;
        case (op)
            7'h37: begin e.imm = ins & 32'hFFFFF000; has_rd = 1; e.alu = A_PASSB;
                e.alu_src = 1; e.reg_write = 1; end
            7'h17: begin e.imm = ins & 32'hFFFFF000; has_rd = 1; e.alu = A_ADD;
                e.alu_src = 1; e.pc_src = 1; e.reg_write = 1; end
            7'h6F: begin
                e.imm = sx(32'(ins[19:12]) * 4096 + 32'(ins[20]) * 2048 + 32'(ins[30:21]) * 2,
                           ins[31], 20);
                has_rd = 1; e.alu = A_ADD; e.alu_src = 1; e.pc_src = 1; e.reg_write = 1; e.jump = 1;
            end
            7'h67: begin
                bad = (f3 != 0); e.imm = sx(32'(ins[31:20]), ins[31], 12);
                has_rs1 = 1; has_rd = 1; e.alu = A_ADD; e.alu_src = 1; e.pc_src = 1;
                e.reg_write = 1; e.jump = 1;
            end
            7'h63: begin
                bad = (f3 == 2 || f3 == 3);
                e.imm = sx(32'(ins[7]) * 2048 + 32'(ins[30:25]) * 32 + 32'(ins[11:8]) * 2, ins[31], 12);
                has_rs1 = 1; has_rs2 = 1; e.branch = 1;
                e.alu = (f3 >= 6) ? A_SLTU : (f3 >= 4) ? A_SLT : A_SUB;
            end
            7'h03: begin
                bad = !(f3 == 0 || f3 == 1 || f3 == 2 || f3 == 4 || f3 == 5);
                e.imm = sx(32'(ins[31:20]), ins[31], 12); has_rs1 = 1; has_rd = 1;
                e.alu = A_ADD; e.alu_src = 1; e.mem_read = 1; e.mem_to_reg = 1; e.reg_write = 1;
            end
            7'h23: begin
                bad = (f3 > 2);
                e.imm = sx(32'(ins[31:25]) * 32 + 32'(ins[11:7]), ins[31], 12);
                has_rs1 = 1; has_rs2 = 1; e.alu = A_ADD; e.alu_src = 1; e.mem_write = 1;
            end
            7'h13: begin
                e.imm = sx(32'(ins[31:20]), ins[31], 12); has_rs1 = 1; has_rd = 1;
                e.alu_src = 1; e.reg_write = 1;
                e.alu = (f3 == 5 && f7 == 7'h20) ? A_SRA : R_ALU[f3];
                bad = (f3 == 1 && f7 != 0) || (f3 == 5 && f7 != 0 && f7 != 7'h20);
            end
            7'h33: begin
                has_rs1 = 1; has_rs2 = 1; has_rd = 1; e.reg_write = 1;
                if (f7 == 0) e.alu = R_ALU[f3];
                else if (f7 == 7'h20 && f3 == 0) e.alu = A_SUB;
                else if (f7 == 7'h20 && f3 == 5) e.alu = A_SRA;
                else bad = 1;
            end
            7'h0F, 7'h73: ;
            default: bad = 1;
        endcase
        if (has_rs1) e.rs1 = ins[19:15];
        if (has_rs2) e.rs2 = ins[24:20];
        if (has_rd) e.rd = ins[11:7];
        if (has_rs1) e.func3 = f3;
        if (e.rd == 0) e.reg_write = 0;
        if (bad) begin
            e = '0;
            e.pc = pc;
            e.illegal = 1;
        end
        return e;
    endfunction

    function automatic exp_t observed();
        exp_t o;
        o.pc = bus.out_pc; o.imm = bus.out_imm;
        o.rs1 = bus.out_rs1; o.rs2 = bus.out_rs2; o.rd = bus.out_rd;
        o.func3 = bus.out_func3; o.alu = bus.out_alu_ctrl;
        o.alu_src = bus.out_alu_src; o.pc_src = bus.out_pc_src;
        o.mem_read = bus.out_mem_read; o.mem_write = bus.out_mem_write;
        o.reg_write = bus.out_reg_write; o.mem_to_reg = bus.out_mem_to_reg;
        o.branch = bus.out_branch; o.jump = bus.out_jump; o.illegal = bus.out_illegal;
        return o;
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [31:0] ins;
        int unsigned pick;
        ins = $urandom;
        pick = $urandom_range(0, 11);
        if (pick < 11) ins[6:0] = OPS[pick];
        if (ins[6:0] == 7'h33 || ins[6:0] == 7'h13) begin
            case ($urandom_range(0, 3))
                0: ins[31:25] = 7'h00;
                1: ins[31:25] = 7'h20;
                default: ;
            endcase
        end
        return ins;
    endfunction

    // One clock: drive inputs, advance past the edge, update the FIFO model.
    task automatic cycle(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                         input logic ordy, input logic fl);
        logic exp_rdy;
        bus.in_valid = v; bus.in_instr = ins; bus.in_pc = pc;
        bus.out_ready = ordy; bus.flush = fl;
        exp_rdy = (q.size() < 2);
        @(posedge clk);
        if (q.size() > 0 && ordy) void'(q.pop_front());
        if (fl) q.delete();
        else if (v && exp_rdy) q.push_back(ref_decode(ins, pc));
        #1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        bus.in_valid = 0; bus.in_instr = '0; bus.in_pc = '0; bus.out_ready = 0; bus.flush = 0;
        rst = 0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b want=0", bus.out_valid); end
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b want=1", bus.in_ready); end
        checks++; if (observed() !== exp_t'(0)) begin errors++; $display("FAIL reset_bundle got=%h want=0", observed()); end
        @(negedge clk);
        rst = 1;
        q.delete();
    endtask

    task automatic test_basic();
        cycle(1, 32'hFFF00093, 32'h100, 1, 0);
        checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL addi_valid got=%b want=1", bus.out_valid); end
        checks++; if (bus.out_imm !== 32'hFFFFFFFF) begin errors++; $display("FAIL addi_imm got=%h want=ffffffff", bus.out_imm); end
        checks++; if ({bus.out_alu_ctrl, bus.out_alu_src, bus.out_rd, bus.out_reg_write} !== {A_ADD, 1'b1, 5'd1, 1'b1}) begin
            errors++; $display("FAIL addi_ctrl got=%h/%b/%0d/%b want=2/1/1/1", bus.out_alu_ctrl, bus.out_alu_src, bus.out_rd, bus.out_reg_write); end
        cycle(1, 32'h00000463, 32'h104, 1, 0);
        checks++; if (bus.out_imm !== 32'h8) begin errors++; $display("FAIL beq_imm got=%h want=00000008", bus.out_imm); end
        checks++; if ({bus.out_branch, bus.out_alu_ctrl, bus.out_reg_write} !== {1'b1, A_SUB, 1'b0}) begin
            errors++; $display("FAIL beq_ctrl got=%b/%h/%b want=1/6/0", bus.out_branch, bus.out_alu_ctrl, bus.out_reg_write); end
        cycle(1, 32'h123452B7, 32'h108, 1, 0);
        checks++; if (bus.out_imm !== 32'h12345000) begin errors++; $display("FAIL lui_imm got=%h want=12345000", bus.out_imm); end
        checks++; if ({bus.out_alu_ctrl, bus.out_rd, bus.out_reg_write} !== {A_PASSB, 5'd5, 1'b1}) begin
            errors++; $display("FAIL lui_ctrl got=%h/%0d/%b want=a/5/1", bus.out_alu_ctrl, bus.out_rd, bus.out_reg_write); end
        cycle(1, 32'h00000013, 32'h10C, 1, 0);
        checks++; if (bus.out_reg_write !== 1'b0 || bus.out_pc !== 32'h10C) begin
            errors++; $display("FAIL nop_rw got=%b pc=%h want=0 pc=10c", bus.out_reg_write, bus.out_pc); end
        cycle(0, '0, '0, 1, 0);
    endtask

    task automatic test_back_to_back();
        cycle(1, 32'hFFF00093, 32'h200, 0, 0);
        checks++; if (bus.out_pc !== 32'h200 || bus.in_ready !== 1'b1) begin
            errors++; $display("FAIL bp_first got pc=%h rdy=%b want 200/1", bus.out_pc, bus.in_ready); end
        cycle(1, 32'h123452B7, 32'h204, 0, 0);
        checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL bp_full_rdy got=%b want=0", bus.in_ready); end
        cycle(1, 32'h00000463, 32'h208, 0, 0);
        checks++; if (bus.out_pc !== 32'h200 || bus.in_ready !== 1'b0 || bus.out_imm !== 32'hFFFFFFFF) begin
            errors++; $display("FAIL bp_hold got pc=%h rdy=%b imm=%h want 200/0/ffffffff", bus.out_pc, bus.in_ready, bus.out_imm); end
        cycle(0, '0, '0, 1, 0);
        checks++; if (bus.out_pc !== 32'h204 || bus.out_imm !== 32'h12345000 || bus.in_ready !== 1'b1) begin
            errors++; $display("FAIL bp_release got pc=%h imm=%h rdy=%b want 204/12345000/1", bus.out_pc, bus.out_imm, bus.in_ready); end
        cycle(0, '0, '0, 1, 0);
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL bp_drained got=%b want=0", bus.out_valid); end
        cycle(1, 32'h00000463, 32'h208, 1, 0);
        checks++; if (bus.out_pc !== 32'h208 || bus.out_branch !== 1'b1) begin
            errors++; $display("FAIL bp_resend got pc=%h br=%b want 208/1", bus.out_pc, bus.out_branch); end
        cycle(0, '0, '0, 1, 0);
    endtask

    task automatic test_flush();
        cycle(1, 32'hFFF00093, 32'h300, 0, 0);
        cycle(1, 32'h123452B7, 32'h304, 0, 0);
        checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL flush_pre_rdy got=%b want=0", bus.in_ready); end
        cycle(1, 32'h00000463, 32'h308, 0, 1);
        checks++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            errors++; $display("FAIL flush_state got valid=%b rdy=%b want 0/1", bus.out_valid, bus.in_ready); end
        cycle(0, '0, '0, 1, 0);
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL flush_no_beat got=%b want=0", bus.out_valid); end
    endtask

    task automatic test_illegal();
        cycle(1, 32'h00000000, 32'h400, 1, 0);
        checks++; if ({bus.out_illegal, bus.out_reg_write, bus.out_mem_read, bus.out_mem_write, bus.out_branch, bus.out_jump} !== 6'b100000) begin
            errors++; $display("FAIL ill_zero got=%b%b%b%b%b%b want=100000", bus.out_illegal, bus.out_reg_write,
                bus.out_mem_read, bus.out_mem_write, bus.out_branch, bus.out_jump); end
        cycle(1, 32'h40001033, 32'h404, 1, 0);
        checks++; if ({bus.out_valid, bus.out_illegal, bus.out_reg_write} !== 3'b110 || bus.out_pc !== 32'h404) begin
            errors++; $display("FAIL ill_funct7 got v=%b ill=%b rw=%b pc=%h want 1/1/0/404", bus.out_valid, bus.out_illegal, bus.out_reg_write, bus.out_pc); end
        cycle(1, 32'h00000073, 32'h408, 1, 0);
        checks++; if (bus.out_illegal !== 1'b0 || bus.out_reg_write !== 1'b0) begin
            errors++; $display("FAIL ecall_nop got ill=%b rw=%b want 0/0", bus.out_illegal, bus.out_reg_write); end
        cycle(0, '0, '0, 1, 0);
    endtask

    task automatic test_random();
        exp_t o;
        for (int n = 0; n < 1500; n++) begin
            cycle($urandom_range(0, 3) != 0, rand_instr(), $urandom, $urandom_range(0, 2) != 0,
                  $urandom_range(0, 31) == 0);
            checks++; if (bus.out_valid !== (q.size() > 0)) begin
                errors++; $display("FAIL rand_valid n=%0d got=%b want=%b", n, bus.out_valid, q.size() > 0); end
            checks++; if (bus.in_ready !== (q.size() < 2)) begin
                errors++; $display("FAIL rand_ready n=%0d got=%b want=%b", n, bus.in_ready, q.size() < 2); end
            if (q.size() > 0) begin
                o = observed();
                checks++; if (o !== q[0]) begin
                    errors++; $display("FAIL rand_bundle n=%0d got=%h want=%h", n, o, q[0]); end
            end
        end
        cycle(0, '0, '0, 1, 0);
        cycle(0, '0, '0, 1, 0);
    endtask

    task automatic test_reset_mid();
        cycle(1, 32'hFFF00093, 32'h500, 0, 0);
        cycle(1, 32'h00000463, 32'h504, 0, 0);
        #2 rst = 0;
        #1;
        checks++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            errors++; $display("FAIL rstmid_hs got valid=%b rdy=%b want 0/1", bus.out_valid, bus.in_ready); end
        checks++; if (observed() !== exp_t'(0)) begin errors++; $display("FAIL rstmid_bundle got=%h want=0", observed()); end
        q.delete();
        @(negedge clk);
        rst = 1;
        cycle(1, 32'h123452B7, 32'h508, 1, 0);
        checks++; if (bus.out_pc !== 32'h508 || bus.out_imm !== 32'h12345000) begin
            errors++; $display("FAIL rstmid_resume got pc=%h imm=%h want 508/12345000", bus.out_pc, bus.out_imm); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_flush();
        test_illegal();
        test_random();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
